// File: rtl/pa_f_spsram_init.sv
`default_nettype none
// ============================================================================
// Module   : pa_f_spsram_init
// Purpose  : FPGA single-port SRAM built from per-bit 1-bit RAMs. Provides
//            per-bit masked writes and write-first read data. Read latency is
//            1 cycle, or 2 with OUT_REG. Q holds when no access is made.
//            A clear sequencer sweeps every word to INIT_VALUE after reset
//            (INIT_EN) and whenever INIT_REQ is pulsed in READY.
// Revision : 1.0 - initial release
// ============================================================================
module pa_f_spsram_init #(
    parameter int                    ADDR_WIDTH = 6,
    parameter int                    DATA_WIDTH = 44,
    parameter int                    OUT_REG    = 0,
    parameter int                    INIT_EN    = 1,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [ADDR_WIDTH-1:0] A,
    input  logic                  CEN,
    input  logic                  GWEN,
    input  logic [DATA_WIDTH-1:0] WEN,
    input  logic [DATA_WIDTH-1:0] D,
    input  logic                  INIT_REQ,
    output logic [DATA_WIDTH-1:0] Q,
    output logic                  INIT_BUSY,
    output logic                  INIT_DONE
);

    localparam int                    DEPTH       = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] c_LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic [0:0] {
        ST_READY = 1'b0,
        ST_INIT  = 1'b1
    } state_t;

    state_t                  state_q;
    logic [ADDR_WIDTH-1:0]   cnt_q;
    logic                    done_q;

    logic                    w_acc;
    logic                    w_wr_acc;
    logic                    w_sweep_we;
    logic [ADDR_WIDTH-1:0]   w_ram_addr;
    logic [DATA_WIDTH-1:0]   rd_d;
    logic [DATA_WIDTH-1:0]   rd_q;

    // Clear sequencer: READY <-> INIT, sweep counter and one-cycle done pulse
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= (INIT_EN != 0) ? ST_INIT : ST_READY;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_READY: begin
                    if (INIT_REQ) begin
                        state_q <= ST_INIT;
                    end
                end
                ST_INIT: begin
                    if (cnt_q == c_LAST_ADDR) begin
                        state_q <= ST_READY;
                        cnt_q   <= '0;
                        done_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_READY;
                end
            endcase
        end
    end

    assign INIT_BUSY = (state_q == ST_INIT);
    assign INIT_DONE = done_q;

    // Nothing lands in the array while reset is held, so an aborted sweep
    // stops cleanly at the word it had reached.
    assign w_acc      = (state_q == ST_READY) & ~CEN & ~RST;
    assign w_wr_acc   = w_acc & ~GWEN;
    assign w_sweep_we = (state_q == ST_INIT) & ~RST;
    assign w_ram_addr = w_sweep_we ? cnt_q : A;

    // One 1-bit RAM per data bit, each with its own write enable; the sweep
    // enable is OR-ed into every bit.
    for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_bit
        logic bit_mem [DEPTH];
        logic w_bit_acc_we;
        logic w_bit_we;
        logic w_bit_wd;

        assign w_bit_acc_we = w_wr_acc & ~WEN[gi];
        assign w_bit_we     = w_sweep_we | w_bit_acc_we;
        assign w_bit_wd     = w_sweep_we ? INIT_VALUE[gi] : D[gi];

        // Array write; contents are deliberately not reset
        always_ff @(posedge CLK) begin
            if (w_bit_we) begin
                bit_mem[w_ram_addr] <= w_bit_wd;
            end
        end

        // Write-first: an enabled bit returns the new data, others the old
        assign rd_d[gi] = w_bit_acc_we ? D[gi] : bit_mem[A];
    end

    // First read stage: only updated by an accepted access, so it holds
    // across idle cycles and is not disturbed by sweep writes.
    always_ff @(posedge CLK) begin
        if (RST) begin
            rd_q <= '0;
        end else if (w_acc) begin
            rd_q <= rd_d;
        end
    end

    if (OUT_REG != 0) begin : g_out_reg
        logic [DATA_WIDTH-1:0] q_q;

        // Extra output stage; follows the first stage every cycle
        always_ff @(posedge CLK) begin
            if (RST) begin
                q_q <= '0;
            end else begin
                q_q <= rd_q;
            end
        end

        assign Q = q_q;
    end else begin : g_no_out_reg
        assign Q = rd_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_pa_f_spsram_init.sv
`default_nettype none
// ============================================================================
// Module   : tb_pa_f_spsram_init
// Purpose  : Directed bench for pa_f_spsram_init. Three instances share one
//            stimulus stream: u0 (latency 1, auto clear), u1 (latency 2,
//            auto clear), u2 (latency 2, no clear after reset).
//            Read results are predicted from a reference model and queued
//            with the cycle they are due in.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pa_f_spsram_init;

    localparam int AW = 6;
    localparam int DW = 44;
    localparam int NDUT = 3;

    logic          CLK;
    logic          RST;
    logic [AW-1:0] A;
    logic          CEN;
    logic          GWEN;
    logic [DW-1:0] WEN;
    logic [DW-1:0] D;
    logic          INIT_REQ;

    logic [DW-1:0] q0, q1, q2;
    logic          busy0, busy1, busy2;
    logic          done0, done1, done2;

    pa_f_spsram_init #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .OUT_REG(0), .INIT_EN(1)) u0 (
        .CLK(CLK), .RST(RST), .A(A), .CEN(CEN), .GWEN(GWEN), .WEN(WEN), .D(D),
        .INIT_REQ(INIT_REQ), .Q(q0), .INIT_BUSY(busy0), .INIT_DONE(done0));

    pa_f_spsram_init #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .OUT_REG(1), .INIT_EN(1)) u1 (
        .CLK(CLK), .RST(RST), .A(A), .CEN(CEN), .GWEN(GWEN), .WEN(WEN), .D(D),
        .INIT_REQ(INIT_REQ), .Q(q1), .INIT_BUSY(busy1), .INIT_DONE(done1));

    pa_f_spsram_init #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .OUT_REG(1), .INIT_EN(0)) u2 (
        .CLK(CLK), .RST(RST), .A(A), .CEN(CEN), .GWEN(GWEN), .WEN(WEN), .D(D),
        .INIT_REQ(INIT_REQ), .Q(q2), .INIT_BUSY(busy2), .INIT_DONE(done2));

    typedef struct {
        int            due;
        int            dut;
        logic [DW-1:0] exp;
        string         tag;
    } sb_t;

    sb_t           sbq[$];
    logic [DW-1:0] model [NDUT][64];
    int            cyc = 0;
    int            n_checks = 0;
    int            n_pass = 0;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    function automatic int lat(input int k);
        return (k == 0) ? 1 : 2;
    endfunction

    function automatic logic [DW-1:0] qof(input int k);
        case (k)
            0:       return q0;
            1:       return q1;
            default: return q2;
        endcase
    endfunction

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        CEN = 1'b1; GWEN = 1'b1; WEN = '1; D = '0; A = '0; INIT_REQ = 1'b0;
    endtask

    task automatic clear_model(input int k);
        for (int i = 0; i < 64; i++) model[k][i] = '0;
    endtask

    // One access cycle; instances flagged ready in rdy get a prediction queued
    task automatic access(input logic [AW-1:0] a, input logic wr, input logic [DW-1:0] d,
                          input logic [DW-1:0] wen, input logic [NDUT-1:0] rdy, input string tag);
        logic [DW-1:0] e;
        A = a; CEN = 1'b0; GWEN = ~wr; D = d; WEN = wen;
        for (int k = 0; k < NDUT; k++) begin
            if (rdy[k]) begin
                e = model[k][a];
                if (wr) begin
                    e = (e & wen) | (d & ~wen);
                    model[k][a] = e;
                end
                if (^e !== 1'bx) sbq.push_back('{cyc + lat(k), k, e, $sformatf("%s_u%0d", tag, k)});
            end
        end
        tick();
        idle();
    endtask

    // Scoreboard: compare queued predictions in the cycle they fall due
    always @(negedge CLK) begin
        for (int i = sbq.size() - 1; i >= 0; i--) begin
            if (sbq[i].due == cyc) begin
                check(sbq[i].tag, qof(sbq[i].dut), sbq[i].exp);
                sbq.delete(i);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int ndone;
        for (int k = 0; k < NDUT; k++)
            for (int i = 0; i < 64; i++) model[k][i] = 'x;

        // ---- reset ----
        RST = 1'b1;
        idle();
        repeat (3) tick();
        check("rst_q0", q0, '0);
        check("rst_q1", q1, '0);
        check("rst_q2", q2, '0);
        check("rst_done0", 44'(done0), 44'd0);
        check("rst_busy0", 44'(busy0), 44'd1);
        check("rst_busy2", 44'(busy2), 44'd0);

        // ---- power-up sweep ----
        RST = 1'b0;
        n = 0;
        while (busy0 === 1'b1 && n < 200) begin
            n++;
            tick();
        end
        check("sweep_len", 44'(n), 44'd64);
        check("sweep_done0", 44'(done0), 44'd1);
        check("sweep_done1", 44'(done1), 44'd1);
        check("sweep_busy0_end", 44'(busy0), 44'd0);
        tick();
        check("done_pulse_end", 44'(done0), 44'd0);
        clear_model(0);
        clear_model(1);

        // ---- cleared words, back-to-back ----
        access(6'd0,  1'b0, '0, '1, 3'b111, "rd0");
        access(6'd31, 1'b0, '0, '1, 3'b111, "rd31");
        access(6'd63, 1'b0, '0, '1, 3'b111, "rd63");

        // ---- write then read next cycle ----
        access(6'd5, 1'b1, 44'hABC_DEAD_BEEF, '0, 3'b111, "wr5");
        access(6'd5, 1'b0, '0, '1, 3'b111, "rd5");

        // ---- masked writes ----
        access(6'd9, 1'b1, 44'hFFF_FFFF_FFFF, '0, 3'b111, "wr9");
        access(6'd9, 1'b1, 44'h0, 44'hFFF_FFFF_FF00, 3'b111, "wr9_mask");
        access(6'd9, 1'b0, '0, '1, 3'b111, "rd9_mask");
        access(6'd9, 1'b1, 44'h0, '1, 3'b111, "wr9_nobits");
        access(6'd9, 1'b0, '0, '1, 3'b111, "rd9_keep");

        // ---- hold across a requested sweep ----
        access(6'd3, 1'b1, 44'h123, '0, 3'b111, "wr3");
        access(6'd3, 1'b0, '0, '1, 3'b111, "rd3");
        repeat (3) tick();
        INIT_REQ = 1'b1;
        tick();
        idle();
        n = 0;
        while (busy0 === 1'b1 && n < 200) begin
            if (n < 10) begin
                check("hold_q0", q0, 44'h123);
                check("hold_q1", q1, 44'h123);
                check("hold_q2", q2, 44'h123);
            end
            n++;
            idle();
            if (n == 3) begin
                A = 6'd3; CEN = 1'b0; GWEN = 1'b0; WEN = '0; D = '1;
            end else if (n == 5) begin
                INIT_REQ = 1'b1;
            end
            tick();
        end
        idle();
        check("req_sweep_len", 44'(n), 44'd64);
        check("req_done0", 44'(done0), 44'd1);
        check("req_done2", 44'(done2), 44'd1);
        check("req_busy2_end", 44'(busy2), 44'd0);
        check("hold_after_sweep0", q0, 44'h123);
        check("hold_after_sweep1", q1, 44'h123);
        tick();
        for (int k = 0; k < NDUT; k++) clear_model(k);
        access(6'd3, 1'b0, '0, '1, 3'b111, "rd3_cleared");

        // ---- reset abort at sweep count 20 ----
        INIT_REQ = 1'b1;
        tick();
        idle();
        ndone = 0;
        repeat (20) begin
            if (done0 === 1'b1) ndone++;
            tick();
        end
        RST = 1'b1;
        tick();
        RST = 1'b0;
        check("abort_q0", q0, '0);
        check("abort_q1", q1, '0);
        check("abort_q2", q2, '0);
        check("abort_busy0", 44'(busy0), 44'd1);
        check("abort_busy2", 44'(busy2), 44'd0);
        n = 0;
        while (busy0 === 1'b1 && n < 200) begin
            if (done0 === 1'b1) ndone++;
            n++;
            if (n == 1)
                access(6'd63, 1'b1, 44'h5A5_A5A5_A5A5, '0, 3'b100, "wr63_noinit");
            else if (n == 2)
                access(6'd63, 1'b0, '0, '1, 3'b100, "rd63_noinit");
            else
                tick();
        end
        if (done0 === 1'b1) ndone++;
        check("abort_sweep_len", 44'(n), 44'd64);
        tick();
        if (done0 === 1'b1) ndone++;
        check("abort_done_once", 44'(ndone), 44'd1);
        clear_model(0);
        clear_model(1);

        // ---- final mixed traffic ----
        access(6'd63, 1'b0, '0, '1, 3'b111, "rd63_final");
        access(6'd17, 1'b1, 44'h111_2222_3333, '0, 3'b111, "wr17");
        access(6'd18, 1'b1, 44'hABC_0000_1234, '0, 3'b111, "wr18");
        access(6'd17, 1'b0, '0, '1, 3'b111, "rd17");
        access(6'd18, 1'b0, '0, '1, 3'b111, "rd18");
        access(6'd17, 1'b1, '1, 44'h0FF_FFFF_FFFF, 3'b111, "wr17_top");
        access(6'd17, 1'b0, '0, '1, 3'b111, "rd17_top");
        repeat (4) tick();
        check("sb_drain", 44'(sbq.size()), 44'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pa_f_spsram_init.md
Name: pa_f_spsram_init

Overview:
- Parametrised FPGA single-port SRAM with a hardware clear sequencer.
- Provides per-bit masked writes, a read latency of 1 or 2 cycles, and output hold when the array is not selected.
- After reset, and on request, an FSM sweeps the whole array to INIT_VALUE before it accepts accesses.
- Target is cache tag/valid arrays that must power up clean on FPGA builds.

Parameters:
ADDR_WIDTH, 6, address bits; DEPTH = 2**ADDR_WIDTH
DATA_WIDTH, 44, word width
OUT_REG, 0, 0 = read latency 1; 1 = extra output register, read latency 2
INIT_EN, 1, 1 = clear sweep runs automatically after reset; 0 = array is ready after reset, contents undefined
INIT_VALUE, 0, DATA_WIDTH-bit value written to every word during a sweep

Ports:
CLK  in  1  clock; all state updates on posedge
RST  in  1  synchronous reset, active-high
A  in  ADDR_WIDTH  access address
CEN  in  1  chip enable, active-low
GWEN  in  1  global write enable, active-low
WEN  in  DATA_WIDTH  per-bit write enable, active-low
D  in  DATA_WIDTH  write data
INIT_REQ  in  1  single-cycle pulse that starts a clear sweep; sampled only in READY
Q  out  DATA_WIDTH  read data
INIT_BUSY  out  1  high while a sweep is in progress; accesses are ignored
INIT_DONE  out  1  single-cycle pulse in the cycle after the last sweep write

Behaviour:
- Reset values, with RST high at a posedge: Q=0, pipeline register=0, INIT_DONE=0, sweep counter=0, address hold register=0.
  - State after reset is INIT when INIT_EN=1, so INIT_BUSY=1 from the next cycle on.
  - State after reset is READY when INIT_EN=0, so INIT_BUSY=0.
  - Array contents are not reset.
- FSM states: READY, INIT.
  - READY -> INIT when INIT_REQ=1. INIT_BUSY rises the next cycle.
  - INIT writes INIT_VALUE to address cnt each cycle, with all bits enabled. cnt counts 0..DEPTH-1.
  - INIT -> READY after the write to DEPTH-1. INIT_DONE pulses for exactly that transition cycle, and cnt returns to 0.
  - A sweep takes exactly DEPTH cycles with INIT_BUSY=1.
  - INIT_REQ in INIT is ignored; the sweep does not restart.
  - RST in INIT aborts the sweep. With INIT_EN=1 the sweep restarts at address 0; with INIT_EN=0 the state goes to READY and partial contents remain.
- Effective access: acc = READY & !CEN. Accesses presented while INIT_BUSY=1 are dropped and produce no Q update.
- Write: acc & !GWEN.
  - Bit i of word A becomes D[i] where WEN[i]=0 and keeps its old value where WEN[i]=1.
  - All WEN bits high means no bits change.
- Read: acc & GWEN.
  - OUT_REG=0: Q = mem[A] at the posedge ending the access cycle (latency 1).
  - OUT_REG=1: the pipeline register captures mem[A] at that posedge and Q follows one posedge later (latency 2).
- Write cycle output is write-first: Q, after the same latency, carries the merged new word of the written address.
- Hold: when no access occurs, the address hold register is unchanged and Q is unchanged.
  - Q is not re-read from the held address.
  - A later write to the held address by a sweep does not disturb Q.
- Back-to-back accesses: every cycle is accepted with full throughput.
  - Read-after-write to the same address in the next cycle returns the new data.
- A is used as an index modulo DEPTH; there are no out-of-range addresses.
- INIT_DONE is only ever a single-cycle pulse; INIT_BUSY and INIT_DONE are never high together.
- Each bit is built from a generated per-bit 1-bit RAM with its own write enable, the same structure as the existing FPGA spsram wrappers. Sweep enables are OR-ed into all bits.

Test Plan:
- Reset with INIT_EN=1, DEPTH=64 -> INIT_BUSY=1 for exactly 64 cycles, then INIT_DONE for 1 cycle; reads of addresses 0, 31 and 63 return 44'h0.
- OUT_REG=0: write D=44'hABC_DEAD_BEEF to A=5, then read A=5 in the next cycle -> Q=44'hABC_DEAD_BEEF one cycle after the read. With OUT_REG=1 the same sequence gives the value two cycles after the read.
- Masked write: word 9 = 44'hFFF_FFFF_FFFF; write D=0 with WEN=44'hFFF_FFFF_FF00 -> a read returns 44'hFFF_FFFF_FF00.
- Read A=3 (value 0x123), then hold CEN=1 for 10 cycles while INIT_REQ triggers a sweep -> Q stays 0x123 throughout; a write presented during INIT_BUSY is dropped, and a later read shows INIT_VALUE.
- Assert RST at sweep count 20 -> the sweep restarts at 0 and takes 64 full cycles; INIT_DONE pulses only once, at the end.
- INIT_EN=0: after reset INIT_BUSY=0, and a write then read at A=63 works immediately with latency per OUT_REG.
